// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: TX FIFO, single-entry RX holding register, sticky error flags, programmable divisor.
// Define BUS_UART_IRQ_EN to turn register 3 into IRQ_EN and add the irq_o output.
module bus_uart #(
  parameter int unsigned TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        enable_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wvalue_i,
  output logic [31:0] rvalue_o,
  output logic        tx_o,
  input  logic        rx_i
`ifdef BUS_UART_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IRQ    = 2'd3;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;

  logic [1:0]    reg_sel_c;
  logic          wr_c, rd_c, push_c, st_wr_c, rx_pop_c, tx_pop_c, rx_deliver_c;
  logic          tx_empty_c, tx_full_c, tx_busy_c;
  logic [15:0]   div_eff_c, rx_half_c;

  logic [15:0]   divisor;
  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          tx_drop, rx_ovr, rx_valid;
  logic [7:0]    rx_byte;

  tx_state_t     tx_state;
  logic [15:0]   tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;

  rx_state_t     rx_state;
  logic [15:0]   rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_s1, rx_s2, rx_prev;

  logic          unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wvalue_i[31:16], wstrb_i[3:2]};

  assign reg_sel_c  = addr_i[3:2];
  assign wr_c       = enable_i && (wstrb_i != 4'd0);
  assign rd_c       = enable_i && (wstrb_i == 4'd0);
  assign push_c     = wr_c && (reg_sel_c == REG_DATA) && wstrb_i[0];
  assign st_wr_c    = wr_c && (reg_sel_c == REG_STATUS) && wstrb_i[0];
  assign rx_pop_c   = rd_c && (reg_sel_c == REG_DATA);

  assign tx_empty_c = (wr_ptr == rd_ptr);
  assign tx_full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_busy_c  = (tx_state != T_IDLE);
  assign div_eff_c  = (divisor == 16'd0) ? 16'd1 : divisor;
  assign rx_half_c  = (div_eff_c[15:1] == 15'd0) ? 16'd1 : {1'b0, div_eff_c[15:1]};

  // TX pops in IDLE, or at the end of STOP for back-to-back frames
  assign tx_pop_c = !tx_empty_c &&
                    ((tx_state == T_IDLE) || ((tx_state == T_STOP) && (tx_cnt == 16'd0)));
  assign rx_deliver_c = (rx_state == R_STOP) && (rx_cnt == 16'd0) && rx_s2;

  always_ff @(posedge clk_i) begin
    if (push_c && !tx_full_c) fifo_mem[wr_ptr[AW-1:0]] <= wvalue_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tx_drop <= 1'b0;
    end else begin
      if (push_c && !tx_full_c) wr_ptr <= wr_ptr + PW'(1);
      if (tx_pop_c) rd_ptr <= rd_ptr + PW'(1);
      if (push_c && tx_full_c)            tx_drop <= 1'b1;
      else if (st_wr_c && wvalue_i[5])    tx_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      divisor <= DEFAULT_DIV;
    end else if (wr_c && (reg_sel_c == REG_DIV)) begin
      if (wstrb_i[0]) divisor[7:0]  <= wvalue_i[7:0];
      if (wstrb_i[1]) divisor[15:8] <= wvalue_i[15:8];
    end
  end

  // Transmit FSM; bit timer reloads from the current divisor at every bit boundary
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_state <= T_IDLE;
      tx_o     <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'd0;
    end else if (tx_state == T_IDLE) begin
      if (tx_pop_c) begin
        tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
        tx_o     <= 1'b0;
        tx_cnt   <= div_eff_c - 16'd1;
        tx_state <= T_START;
      end
    end else if (tx_cnt != 16'd0) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else begin
      tx_cnt <= div_eff_c - 16'd1;
      case (tx_state)
        T_START: begin
          tx_o     <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_idx   <= 3'd0;
          tx_state <= T_DATA;
        end
        T_DATA: begin
          if (tx_idx == 3'd7) begin
            tx_o     <= 1'b1;
            tx_state <= T_STOP;
          end else begin
            tx_o     <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= tx_idx + 3'd1;
          end
        end
        default: begin
          if (tx_pop_c) begin
            tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
            tx_o     <= 1'b0;
            tx_state <= T_START;
          end else begin
            tx_state <= T_IDLE;
          end
        end
      endcase
    end
  end

  // Receive synchronizer, edge detect and FSM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= R_IDLE;
      rx_cnt   <= 16'd0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= rx_half_c - 16'd1;
            rx_state <= R_START;
          end
        end
        R_BREAK: begin
          if (rx_s2) rx_state <= R_IDLE;
        end
        default: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_cnt <= div_eff_c - 16'd1;
            if (rx_state == R_START) begin
              rx_idx   <= 3'd0;
              rx_state <= rx_s2 ? R_IDLE : R_DATA;
            end else if (rx_state == R_DATA) begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              if (rx_idx == 3'd7) rx_state <= R_STOP;
              else                rx_idx   <= rx_idx + 3'd1;
            end else begin
              rx_state <= rx_s2 ? R_IDLE : R_BREAK;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_valid <= 1'b0;
      rx_byte  <= 8'd0;
      rx_ovr   <= 1'b0;
    end else begin
      if (rx_deliver_c && (!rx_valid || rx_pop_c)) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_pop_c) begin
        rx_valid <= 1'b0;
      end
      if (rx_deliver_c && rx_valid && !rx_pop_c) rx_ovr <= 1'b1;
      else if (st_wr_c && wvalue_i[4])           rx_ovr <= 1'b0;
    end
  end

`ifdef BUS_UART_IRQ_EN
  logic [1:0] irq_en;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_en <= 2'd0;
      irq_o  <= 1'b0;
    end else begin
      if (wr_c && (reg_sel_c == REG_IRQ) && wstrb_i[0]) irq_en <= wvalue_i[1:0];
      irq_o <= (irq_en[0] && rx_valid) || (irq_en[1] && tx_empty_c && !tx_busy_c);
    end
  end
`endif

  // Read data is captured on the read edge and held until the next read
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalue_o <= 32'd0;
    end else if (rd_c) begin
      case (reg_sel_c)
        REG_DATA:   rvalue_o <= {23'd0, rx_valid, rx_byte};
        REG_STATUS: rvalue_o <= {26'd0, tx_drop, rx_ovr, rx_valid, tx_busy_c, tx_empty_c, tx_full_c};
        REG_DIV:    rvalue_o <= {16'd0, divisor};
`ifdef BUS_UART_IRQ_EN
        default:    rvalue_o <= {30'd0, irq_en};
`else
        default:    rvalue_o <= 32'd0;
`endif
      endcase
    end
  end

endmodule
